// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and defaults for the uart_tx arbiter
package uart_arb_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEF_ACK_TIMEOUT = 16;
    localparam int DEF_GAP_TIMEOUT = 1_000_000;
    localparam int DEF_CW          = 20;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - round-robin one-hot pick starting at a pointer, with wrap
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic             any
);

    // Upper scan from the pointer first, then wrap around from bit 0.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                pick[i] = 1'b1;
                any     = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i]) begin
                pick[i] = 1'b1;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-atomic round-robin sharing of one uart_tx among N_REQ byte streams
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT,
    parameter int CW          = DEF_CW
) (
    input  logic                      clk_100m,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          grant,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_wr_en,
    input  logic                      tx_busy,
    input  logic                      err_clear,
    output logic                      err_ack,
    output logic                      err_gap
);

    localparam int PW = ptr_w(N_REQ);

    arb_state_t         state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_wr_en_q, tx_wr_en_d;
    logic               last_q, last_d;
    logic               err_ack_q, err_ack_d;
    logic               err_gap_q, err_gap_d;

    logic [N_REQ-1:0]   pick;
    logic               pick_any;
    logic               g_valid, g_last;
    logic [BYTE_W-1:0]  g_data;
    logic [PW-1:0]      g_idx, g_next;
    logic               set_ack, set_gap, byte_done;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req  (req_valid),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (pick_any)
    );

    // Owner mux: everything the FSM needs to know about the granted requester.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        g_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[BYTE_W*i +: BYTE_W];
                g_idx   = PW'(i);
            end
        end
        g_next  = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + PW'(1);
        cnt_inc = cnt_q + CW'(1);
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_wr_en_d = 1'b0;
        last_d     = last_q;
        req_ready  = '0;
        set_ack    = 1'b0;
        set_gap    = 1'b0;
        byte_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (g_valid && !tx_busy) begin
                    req_ready  = grant_q;
                    tx_data_d  = g_data;
                    tx_wr_en_d = 1'b1;
                    last_d     = g_last;
                    cnt_d      = '0;
                    state_d    = ST_WAIT_ACK;
                end else if (!g_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(GAP_TIMEOUT)) begin
                        set_gap = 1'b1;
                        grant_d = '0;
                        ptr_d   = g_next;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_ACK: begin
                cnt_d = cnt_inc;
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_inc == CW'(ACK_TIMEOUT)) begin
                    set_ack   = 1'b1;
                    byte_done = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A finished byte either closes the message or goes back for the next one.
        if (byte_done) begin
            cnt_d = '0;
            if (last_q) begin
                grant_d = '0;
                ptr_d   = g_next;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_SEND;
            end
        end

        err_ack_d = err_clear ? 1'b0 : (err_ack_q | set_ack);
        err_gap_d = err_clear ? 1'b0 : (err_gap_q | set_gap);
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_wr_en_q <= 1'b0;
            last_q     <= 1'b0;
            err_ack_q  <= 1'b0;
            err_gap_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_wr_en_q <= tx_wr_en_d;
            last_q     <= last_d;
            err_ack_q  <= err_ack_d;
            err_gap_q  <= err_gap_d;
        end
    end

    assign grant    = grant_q;
    assign tx_data  = tx_data_q;
    assign tx_wr_en = tx_wr_en_q;
    assign err_ack  = err_ack_q;
    assign err_gap  = err_gap_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed-vector bench for uart_tx_arbiter
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 10;

    logic           clk_100m = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic [7:0]     tx_data;
    logic           tx_wr_en, tx_busy, err_clear, err_ack, err_gap;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .ACK_TIMEOUT (16),
        .GAP_TIMEOUT (50),
        .CW          (20)
    ) dut (
        .clk_100m  (clk_100m),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_wr_en  (tx_wr_en),
        .tx_busy   (tx_busy),
        .err_clear (err_clear),
        .err_ack   (err_ack),
        .err_gap   (err_gap)
    );

    always #5 clk_100m = ~clk_100m;

    // uart_tx stand-in: ignores rst_n, busy for FRAME cycles starting the cycle after a write
    logic busy_en;
    int   busy_cnt = 0;
    always @(posedge clk_100m) begin
        if (busy_cnt != 0)              busy_cnt <= busy_cnt - 1;
        else if (tx_wr_en && busy_en)   busy_cnt <= FRAME;
    end
    assign tx_busy = (busy_cnt != 0);

    int         cyc = 0, wr_n = 0, rdy_n = 0, viol = 0;
    logic [7:0] wr_data [64];
    int         wr_t    [64];
    int         rdy_idx [64];
    int         rdy_t   [64];

    always @(negedge clk_100m) begin
        cyc++;
        if (tx_wr_en === 1'b1 && wr_n < 64) begin
            wr_data[wr_n] = tx_data;
            wr_t[wr_n]    = cyc;
            wr_n++;
        end
        if (req_ready != '0 && rdy_n < 64) begin
            for (int i = 0; i < N; i++) if (req_ready[i]) rdy_idx[rdy_n] = i;
            rdy_t[rdy_n] = cyc;
            rdy_n++;
        end
        if ($countones(req_ready) > 1 || (req_ready != '0 && tx_busy) ||
            (tx_wr_en && tx_busy) || ((req_ready & ~grant) != '0))
            viol++;
    end

    logic [8:0] rbuf [N][16];
    int         rhead [N];
    int         rtail [N];

    task automatic push(input int r, input logic [8:0] v);
        rbuf[r][rtail[r]] = v;
        rtail[r]++;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
    endtask

    task automatic drive_reqs();
        logic [N-1:0] take;
        forever begin
            @(negedge clk_100m);
            take = req_ready & req_valid;
            @(posedge clk_100m);
            #1;
            for (int i = 0; i < N; i++) begin
                if (take[i] && rhead[i] < rtail[i]) rhead[i]++;
                if (rhead[i] < rtail[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = rbuf[i][rhead[i]][7:0];
                    req_last[i]        = rbuf[i][rhead[i]][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_100m);
        #1;
    endtask

    task automatic wait_idle(input int nwr, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (wr_n >= nwr && grant == '0 && !tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wr(input int nwr, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (wr_n >= nwr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk_100m);
        #1;
        rst_n     = 1'b0;
        err_clear = 1'b0;
        clear_reqs();
        for (int k = 0; k < 20 && tx_busy; k++) tick();
        repeat (2) tick();
        @(posedge clk_100m);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b want 0000", grant); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        vectors++; if (tx_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_tx_wr_en: got %b want 0", tx_wr_en); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        vectors++; if ({err_ack, err_gap} !== 2'b00) begin miscompares++; $display("FAIL reset_errs: got %b want 00", {err_ack, err_gap}); end
        @(posedge clk_100m);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        vectors++; if (grant !== 4'b0000 || tx_wr_en !== 1'b0) begin miscompares++; $display("FAIL idle_no_req: got grant %b wr %b want 0000 0", grant, tx_wr_en); end
    endtask

    task automatic test_single();
        int wb, rb;
        bit ok;
        do_reset();
        wb = wr_n; rb = rdy_n;
        push(0, 9'h041); push(0, 9'h142);
        wait_idle(wb + 2, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_done: got timeout want grant 0 after 2 bytes"); end
        vectors++; if (wr_n - wb !== 2) begin miscompares++; $display("FAIL single_wr_count: got %0d want 2", wr_n - wb); end
        vectors++; if (wr_data[wb] !== 8'h41) begin miscompares++; $display("FAIL single_byte0: got %h want 41", wr_data[wb]); end
        vectors++; if (wr_data[wb+1] !== 8'h42) begin miscompares++; $display("FAIL single_byte1: got %h want 42", wr_data[wb+1]); end
        vectors++; if (rdy_n - rb !== 2 || rdy_idx[rb] !== 0 || rdy_idx[rb+1] !== 0) begin miscompares++; $display("FAIL single_ready: got %0d strobes want 2 on req 0", rdy_n - rb); end
        vectors++; if (wr_t[wb] - rdy_t[rb] !== 1) begin miscompares++; $display("FAIL single_wr_latency: got %0d want 1", wr_t[wb] - rdy_t[rb]); end
        vectors++; if (wr_t[wb+1] - wr_t[wb] !== FRAME + 3) begin miscompares++; $display("FAIL single_byte_period: got %0d want %0d", wr_t[wb+1] - wr_t[wb], FRAME + 3); end
    endtask

    task automatic test_round_robin();
        int wb, rb;
        bit ok;
        logic [7:0] exp_b [8];
        int         exp_r [4];
        exp_b = '{8'h11, 8'h12, 8'h21, 8'h22, 8'h13, 8'h14, 8'h23, 8'h24};
        exp_r = '{1, 1, 2, 2};
        do_reset();
        wb = wr_n; rb = rdy_n;
        for (int round = 0; round < 2; round++) begin
            push(1, {1'b0, exp_b[4*round]});   push(1, {1'b1, exp_b[4*round+1]});
            push(2, {1'b0, exp_b[4*round+2]}); push(2, {1'b1, exp_b[4*round+3]});
            wait_idle(wb + 4*round + 4, 200, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL rr_done round %0d: got timeout want idle", round); end
            for (int k = 0; k < 4; k++) begin
                vectors++; if (wr_data[wb+4*round+k] !== exp_b[4*round+k]) begin miscompares++; $display("FAIL rr_byte r%0d k%0d: got %h want %h", round, k, wr_data[wb+4*round+k], exp_b[4*round+k]); end
                vectors++; if (rdy_idx[rb+4*round+k] !== exp_r[k]) begin miscompares++; $display("FAIL rr_owner r%0d k%0d: got %0d want %0d", round, k, rdy_idx[rb+4*round+k], exp_r[k]); end
            end
        end
    endtask

    // Runs straight after the round-robin rounds, so the pointer sits at 3.
    task automatic test_hold_grant();
        int wb, rb;
        bit ok;
        logic [7:0] exp_b [4];
        int         exp_r [4];
        exp_b = '{8'hA1, 8'hA2, 8'hA3, 8'h01};
        exp_r = '{3, 3, 3, 0};
        wb = wr_n; rb = rdy_n;
        push(3, 9'h0A1); push(3, 9'h0A2); push(3, 9'h1A3); push(0, 9'h101);
        wait_idle(wb + 4, 200, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL hold_done: got timeout want idle"); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (wr_data[wb+k] !== exp_b[k]) begin miscompares++; $display("FAIL hold_byte %0d: got %h want %h", k, wr_data[wb+k], exp_b[k]); end
            vectors++; if (rdy_idx[rb+k] !== exp_r[k]) begin miscompares++; $display("FAIL hold_owner %0d: got %0d want %0d", k, rdy_idx[rb+k], exp_r[k]); end
        end
        vectors++; if (rdy_t[rb+3] - wr_t[wb+2] !== FRAME + 3) begin miscompares++; $display("FAIL hold_handover: got %0d want %0d", rdy_t[rb+3] - wr_t[wb+2], FRAME + 3); end
    endtask

    task automatic test_ack_timeout();
        int wb;
        bit ok;
        do_reset();
        busy_en = 1'b0;
        wb = wr_n;
        push(1, 9'h055); push(1, 9'h156);
        wait_wr(wb + 1, 50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ack_first_wr: got timeout want write"); end
        repeat (15) tick();
        vectors++; if (err_ack !== 1'b0) begin miscompares++; $display("FAIL ack_early: got %b want 0 at cycle 15", err_ack); end
        tick();
        vectors++; if (err_ack !== 1'b1) begin miscompares++; $display("FAIL ack_set: got %b want 1 at cycle 16", err_ack); end
        vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL ack_keeps_grant: got %b want 0010", grant); end
        wait_wr(wb + 2, 10, ok);
        vectors++; if (!ok || wr_data[wb+1] !== 8'h56) begin miscompares++; $display("FAIL ack_next_byte: got %h want 56", wr_data[wb+1]); end
        vectors++; if (wr_t[wb+1] - wr_t[wb] !== 17) begin miscompares++; $display("FAIL ack_next_spacing: got %0d want 17", wr_t[wb+1] - wr_t[wb]); end
        wait_idle(wb + 2, 40, ok);
        vectors++; if (!ok || err_ack !== 1'b1 || err_gap !== 1'b0) begin miscompares++; $display("FAIL ack_sticky: got ack %b gap %b want 1 0", err_ack, err_gap); end
        @(posedge clk_100m); #1; err_clear = 1'b1;
        @(posedge clk_100m); #1; err_clear = 1'b0;
        tick();
        vectors++; if (err_ack !== 1'b0) begin miscompares++; $display("FAIL ack_clear: got %b want 0", err_ack); end
        busy_en = 1'b1;
    endtask

    task automatic test_gap_timeout();
        int wb;
        bit ok;
        do_reset();
        wb = wr_n;
        push(2, 9'h077); push(3, 9'h188);
        wait_wr(wb + 1, 50, ok);
        vectors++; if (!ok || wr_data[wb] !== 8'h77) begin miscompares++; $display("FAIL gap_first_byte: got %h want 77", wr_data[wb]); end
        repeat (61) tick();
        vectors++; if (grant !== 4'b0100 || err_gap !== 1'b0) begin miscompares++; $display("FAIL gap_early: got grant %b gap %b want 0100 0", grant, err_gap); end
        tick();
        vectors++; if (grant !== 4'b0000 || err_gap !== 1'b1) begin miscompares++; $display("FAIL gap_revoke: got grant %b gap %b want 0000 1", grant, err_gap); end
        tick();
        vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL gap_next_owner: got %b want 1000", grant); end
        wait_idle(wb + 2, 60, ok);
        vectors++; if (!ok || wr_data[wb+1] !== 8'h88) begin miscompares++; $display("FAIL gap_next_byte: got %h want 88", wr_data[wb+1]); end
    endtask

    task automatic test_reset_in_frame();
        int wb;
        bit ok;
        do_reset();
        wb = wr_n;
        push(0, 9'h031); push(0, 9'h132);
        wait_wr(wb + 1, 50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rif_first_wr: got timeout want write"); end
        repeat (2) tick();
        @(posedge clk_100m); #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (grant !== 4'b0000 || req_ready !== 4'b0000) begin miscompares++; $display("FAIL rif_async_grant: got grant %b ready %b want 0000 0000", grant, req_ready); end
        vectors++; if (tx_wr_en !== 1'b0 || tx_data !== 8'h00) begin miscompares++; $display("FAIL rif_async_tx: got wr %b data %h want 0 00", tx_wr_en, tx_data); end
        vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL rif_frame_continues: got busy %b want 1", tx_busy); end
        tick();
        @(posedge clk_100m); #1;
        rst_n = 1'b1;
        wait_wr(wb + 2, 40, ok);
        vectors++; if (!ok || wr_data[wb+1] !== 8'h32) begin miscompares++; $display("FAIL rif_resume_byte: got %h want 32", wr_data[wb+1]); end
        vectors++; if (wr_t[wb+1] - wr_t[wb] !== FRAME + 2) begin miscompares++; $display("FAIL rif_resume_time: got %0d want %0d", wr_t[wb+1] - wr_t[wb], FRAME + 2); end
        wait_idle(wb + 2, 40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rif_done: got timeout want idle"); end
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        err_clear = 1'b0;
        busy_en   = 1'b1;
        clear_reqs();
        #2 rst_n = 1'b0;
        fork
            drive_reqs();
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_hold_grant();
        test_ack_timeout();
        test_gap_timeout();
        test_reset_in_frame();
        vectors++; if (viol !== 0) begin miscompares++; $display("FAIL handshake_rules: got %0d bad cycles want 0", viol); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
